// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge detector: edge mode codes,
// per-channel FSM state encoding and a counter-width helper.
package edge_pkg;

  // Two-bit per-channel edge mode: bit0 selects rising edges, bit1 falling edges.
  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  // Debounce FSM encoding: bit1 is the accepted level, bit0 marks qualification.
  localparam logic [1:0] ST_LOW     = 2'b00;
  localparam logic [1:0] ST_QUAL_HI = 2'b01;
  localparam logic [1:0] ST_HIGH    = 2'b10;
  localparam logic [1:0] ST_QUAL_LO = 2'b11;

  typedef enum logic [1:0] {
    LOW     = ST_LOW,
    QUAL_HI = ST_QUAL_HI,
    HIGH    = ST_HIGH,
    QUAL_LO = ST_QUAL_LO
  } chan_state_t;

  // Width of the debounce counter; at least one bit so DB_CYCLES=0 still elaborates.
  function automatic int cnt_width(input int db);
    return (db < 1) ? 1 : $clog2(db + 1);
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One edge-detector channel: synchroniser chain, debounce FSM, registered
// edge tick and sticky pending flag.
module edge_chan
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lvl,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       level_out,
  output logic       edge_tick,
  output logic       pending
);

  localparam int            CW     = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  chan_state_t            state;
  chan_state_t            state_next;
  logic [CW-1:0]          count;
  logic [CW-1:0]          count_next;
  logic                   rise_evt;
  logic                   fall_evt;
  logic                   tick_next;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // Shift the raw asynchronous level through the synchroniser flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], lvl};
  end

  // Debounce next-state logic; rise/fall events are Mealy terms on entry to HIGH/LOW.
  always_comb begin
    state_next = state;
    count_next = count;
    rise_evt   = 1'b0;
    fall_evt   = 1'b0;
    unique case (state)
      LOW: begin
        if (sync_lvl) begin
          if (DB_CYCLES == 0) begin
            state_next = HIGH;
            count_next = '0;
            rise_evt   = 1'b1;
          end else begin
            state_next = QUAL_HI;
            count_next = CNT_ONE;
          end
        end
      end
      QUAL_HI: begin
        if (!sync_lvl) begin
          state_next = LOW;
          count_next = '0;
        end else if (count == DB_MAX) begin
          state_next = HIGH;
          count_next = '0;
          rise_evt   = 1'b1;
        end else if (count < DB_MAX) begin
          count_next = count + CNT_ONE;
        end
      end
      HIGH: begin
        if (!sync_lvl) begin
          if (DB_CYCLES == 0) begin
            state_next = LOW;
            count_next = '0;
            fall_evt   = 1'b1;
          end else begin
            state_next = QUAL_LO;
            count_next = CNT_ONE;
          end
        end
      end
      QUAL_LO: begin
        if (sync_lvl) begin
          state_next = HIGH;
          count_next = '0;
        end else if (count == DB_MAX) begin
          state_next = LOW;
          count_next = '0;
          fall_evt   = 1'b1;
        end else if (count < DB_MAX) begin
          count_next = count + CNT_ONE;
        end
      end
      default: begin
        state_next = LOW;
        count_next = '0;
      end
    endcase
  end

  // Only events enabled by the current mode become ticks; mode 00 still tracks the level.
  assign tick_next = (rise_evt & mode[0]) | (fall_evt & mode[1]);

  // The accepted level is HIGH or still qualifying a drop from HIGH.
  assign level_out = (state == HIGH) || (state == QUAL_LO);

  // State, counter, tick and sticky pending registers; a new event beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOW;
      count     <= '0;
      edge_tick <= 1'b0;
      pending   <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      edge_tick <= tick_next;
      pending   <= tick_next | (pending & ~clr);
    end
  end

endmodule

// File: rtl/edge_detector_multi.sv
// Multi-channel edge detector: N_CH independent channels plus one registered
// interrupt line aggregating enabled pending flags.
module edge_detector_multi
  import edge_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   lvl,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   irq_en,
  input  logic [N_CH-1:0]   clr,
  output logic [N_CH-1:0]   level_out,
  output logic [N_CH-1:0]   edge_tick,
  output logic [N_CH-1:0]   pending,
  output logic              irq
);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .lvl       (lvl[i]),
      .mode      (mode[2*i+1:2*i]),
      .clr       (clr[i]),
      .level_out (level_out[i]),
      .edge_tick (edge_tick[i]),
      .pending   (pending[i])
    );
  end

  // Register the OR of enabled pending flags so irq follows one cycle behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= |(pending & irq_en);
  end

endmodule
